// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - operand/op request and result/status bundle for alu_exec
interface alu_exec_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic [2:0]       op;
  logic             start;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;
  logic             done;

  modport master (
    output a_data, b_data, op, start,
    input  result, flags, busy, done
  );

  modport slave (
    input  a_data, b_data, op, start,
    output result, flags, busy, done
  );
endinterface

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - 8-bit ALU stage with single-cycle ops and shift-add MUL
// Flags are {N,V,C,Z}; result is registered and driven onto the shared bus on out_en.
module alu_exec #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             program_mode,
  input  logic             out_en,
  alu_exec_if.slave        bus,
  inout  wire  [WIDTH-1:0] data
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  logic [WIDTH:0]     sum_w, dif_w;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v;
  logic [2*WIDTH-1:0] mul_add, acc_next;

  always_comb begin
    sum_w = {1'b0, bus.a_data} + {1'b0, bus.b_data};
    dif_w = {1'b0, bus.a_data} + {1'b0, ~bus.b_data} + {{WIDTH{1'b0}}, 1'b1};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.op)
      3'b000: begin
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        alu_v = (bus.a_data[WIDTH-1] == bus.b_data[WIDTH-1]) &&
                (sum_w[WIDTH-1] != bus.a_data[WIDTH-1]);
      end
      3'b001: begin
        alu_r = dif_w[WIDTH-1:0];
        // The adder's carry out is "no borrow", so C is its inverse.
        alu_c = ~dif_w[WIDTH];
        alu_v = (bus.a_data[WIDTH-1] != bus.b_data[WIDTH-1]) &&
                (dif_w[WIDTH-1] != bus.a_data[WIDTH-1]);
      end
      3'b010: alu_r = bus.a_data & bus.b_data;
      3'b011: alu_r = bus.a_data | bus.b_data;
      3'b100: alu_r = bus.a_data ^ bus.b_data;
      3'b101: begin
        alu_r = {bus.a_data[WIDTH-2:0], 1'b0};
        alu_c = bus.a_data[WIDTH-1];
      end
      3'b110: begin
        alu_r = {1'b0, bus.a_data[WIDTH-1:1]};
        alu_c = bus.a_data[0];
      end
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    mul_add  = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    acc_next = acc_q + mul_add;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (clr) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      acc_d    = '0;
      a_d      = '0;
      b_d      = '0;
      result_d = '0;
      flags_d  = '0;
    end else if (!program_mode) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.op == 3'b111) begin
              a_d     = bus.a_data;
              b_d     = bus.b_data;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_MUL;
            end else begin
              result_d = alu_r;
              flags_d  = {alu_r[WIDTH-1], alu_v, alu_c, alu_r == '0};
              state_d  = S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_d = acc_next;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            result_d = acc_next[WIDTH-1:0];
            flags_d  = {acc_next[WIDTH-1], 1'b0, |acc_next[2*WIDTH-1:WIDTH],
                        acc_next[WIDTH-1:0] == '0};
            state_d  = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.busy   = (state_q == S_MUL);
  assign bus.done   = (state_q == S_DONE) && !program_mode;
  assign data       = out_en ? result_q : {WIDTH{1'bz}};
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Arithmetic/logic stage directly downstream of the accumulator and B operand register in the 8-bit bus computer.
- Consumes the two operand buses and computes an 8-bit result plus a 4-bit flag word.
- Single-cycle ops complete in one clock; MUL runs an 8-iteration shift-add sequence with a busy/done handshake.
- The registered result is driven onto the shared bidirectional data bus on out_en.

Parameters:
- WIDTH, 8, operand/result/bus width. Only 8 is supported; the iteration counter is sized for 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, active high.
- program_mode  in  1  high = freeze all state; start is ignored.
- a_data  in  8  accumulator operand.
- b_data  in  8  B-register operand.
- op  in  3  operation select:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SHL (A<<1), 110 SHR (A>>1, logical), 111 MUL (low byte of A*B)
- start  in  1  operation request, sampled on the rising edge.
- out_en  in  1  drive result onto data.
- data  inout  8  shared bus: driven with result when out_en=1, else high-Z.
- result  out  8  registered result.
- flags  out  4  registered {N,V,C,Z}.
- busy  out  1  MUL in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, async):
  - result=0x00, flags=0000, busy=0, done=0.
  - State IDLE, iteration counter=0, operand latches=0.
- clr=1 at an edge: same effect as reset, synchronously. Aborts MUL with no done pulse. Priority over start and program_mode.
- program_mode=1 (clr=0):
  - State, counter, partial product, result and flags hold.
  - start is ignored; done forced to 0.
  - On release, MUL resumes at the held iteration.
- States: IDLE, MUL, DONE.
- IDLE, start=1, op!=111:
  - At that edge, result and flags are registered from a_data/b_data; state becomes DONE.
  - done=1 for the following cycle; busy stays 0.
- IDLE, start=1, op=111:
  - At that edge, A and B are latched, product accumulator is cleared, counter=0, state becomes MUL, busy=1.
- MUL, one iteration per edge (8 iterations total):
  - If multiplier bit[counter]=1, add (A<<counter) to the 16-bit accumulator; counter then increments.
  - On the 8th iteration edge: result=accumulator[7:0], flags update, busy=0, state becomes DONE.
- Latency:
  - MUL: done is high in the cycle after the 9th edge counted from the start edge (start edge plus 8 iteration edges).
  - Non-MUL: done is high in the cycle after the start edge.
- DONE: done=1 for exactly one cycle, then IDLE. start seen while in DONE is ignored.
- start while busy: ignored. Operand or op changes during MUL do not affect the result (operands and op are latched).
- Flags update only on completion, never on abort.
  - Z = (result==0).
  - N = result[7].
  - C:
    - ADD: carry out of bit 7.
    - SUB: borrow (A<B unsigned).
    - SHL: A[7].
    - SHR: A[0].
    - MUL: (product[15:8]!=0).
    - AND/OR/XOR: 0.
  - V:
    - ADD: A7==B7 and R7!=A7.
    - SUB: A7!=B7 and R7!=A7.
    - Other ops: 0.
- Arithmetic is modulo 256. SUB is A+~B+1.
- Bus driving:
  - data=result whenever out_en=1, independent of busy and program_mode. While busy it shows the previous result.
  - Never drive data when out_en=0.

Test Plan:
- ADD: a=0x7F, b=0x01, start 1 cycle -> result=0x80, flags N=1 V=1 C=0 Z=0. done high exactly the next cycle; busy never high.
- SUB: a=0x05, b=0x05 -> 0x00, Z=1 C=0. Then a=0x03, b=0x05 -> 0xFE, C=1 N=1 V=0.
- MUL: a=0x0C, b=0x0B -> busy high 8 cycles, done one cycle later, result=0x84, C=0. Then a=0x10, b=0x10 -> 0x00, Z=1 C=1.
- MUL a=0x03, b=0x05 with a changed to 0xFF and start re-pulsed at iteration 3 -> result 0x0F, a single done pulse.
- Abort and freeze:
  - clr at MUL iteration 4 -> result=0, flags=0, busy=0, no done.
  - Separately, program_mode high 3 cycles mid-MUL -> done delayed exactly 3 cycles, correct product.
- Bus and reset:
  - out_en=0 -> data reads Z. out_en=1 after SHL a=0x81 -> data=0x02, C=1.
  - rst low between edges -> outputs clear immediately.
